// File: rtl/ram_pkg.sv
// Shared state encoding, transfer sizes and the byte-count helper for ram_responder.
package ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int IFETCH_BYTES = 10;
    localparam int DATA_BYTES   = 8;

    // The instruction-fetch size only applies to reads.
    function automatic logic [3:0] xfer_bytes(input logic ifetch, input logic write);
        return (ifetch && !write) ? 4'(IFETCH_BYTES) : 4'(DATA_BYTES);
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte-wide single-port storage: synchronous write, asynchronous read, no reset.
module ram_byte_array #(
    parameter int MEM_BYTES = 4096,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram_responder.sv
// Byte-serial RAM responder: one byte per cycle, 8-byte data or 10-byte ifetch reads.
// Define RAM_BOUNDS_CHECK_EN to reject accesses running past MEM_BYTES instead of wrapping.
module ram_responder
    import ram_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RAMuse,
    input  logic        RAMRead,
    input  logic        RAMWrite,
    input  logic        RAMIfetch,
    input  logic [63:0] RAMAddr,
    input  logic [63:0] RAMDataIn,
    output logic [79:0] RAMDataOut,
    output logic        RAMReady,
    output logic        RAMError,
    output logic        RAMBusy
);

    localparam int AW = $clog2(MEM_BYTES);

    state_t        r_state, w_next;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [63:0]   r_wdata;
    logic          r_ifetch, r_write, r_err;
    logic [79:0]   r_dout;

    logic          w_req_ok, w_req_both, w_oob, w_accept, w_reject, w_last, w_we;
    logic [3:0]    w_req_n, w_n;
    logic [AW-1:0] w_mem_addr;
    logic [7:0]    w_wbyte, w_rbyte;

    assign w_req_ok   = RAMuse & (RAMRead ^ RAMWrite);
    assign w_req_both = RAMuse & RAMRead & RAMWrite;
    assign w_req_n    = xfer_bytes(RAMIfetch, RAMWrite);

`ifdef RAM_BOUNDS_CHECK_EN
    // 65-bit sum so addresses near 2^64 cannot wrap past the check.
    logic [64:0] w_end;
    assign w_end = {1'b0, RAMAddr} + 65'(w_req_n);
    assign w_oob = (w_end > 65'(MEM_BYTES));
`else
    assign w_oob = 1'b0;
`endif

    assign w_accept   = (r_state == ST_IDLE) & w_req_ok & ~w_oob;
    assign w_reject   = (r_state == ST_IDLE) & (w_req_both | (w_req_ok & w_oob));
    assign w_n        = xfer_bytes(r_ifetch, r_write);
    assign w_last     = (r_cnt == (w_n - 4'd1));
    assign w_mem_addr = r_addr + AW'(r_cnt);
    assign w_wbyte    = r_wdata[{r_cnt[2:0], 3'b000} +: 8];

    ram_byte_array #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_wbyte),
        .o_rdata (w_rbyte)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)      w_next = ST_ACCESS;
                else if (w_reject) w_next = ST_DONE;
            end
            ST_ACCESS: if (w_last) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        RAMBusy  = (r_state != ST_IDLE);
        RAMReady = (r_state == ST_DONE);
        RAMError = RAMReady & r_err;
        w_we     = (r_state == ST_ACCESS) & r_write;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ifetch <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_dout   <= '0;
        end else if (w_accept) begin
            r_addr   <= RAMAddr[AW-1:0];
            r_wdata  <= RAMDataIn;
            r_ifetch <= RAMIfetch;
            r_write  <= RAMWrite;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            // Clearing here leaves bytes 8-9 zero for data reads.
            if (RAMRead) r_dout <= '0;
        end else if (w_reject) begin
            r_err <= 1'b1;
        end else if (r_state == ST_ACCESS) begin
            if (!r_write) r_dout[{r_cnt, 3'b000} +: 8] <= w_rbyte;
            r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        end
    end

    assign RAMDataOut = r_dout;

endmodule
